// File: rtl/q_proj_pkg.sv
// Shared constants, FSM state type and saturating-add helpers for the Q
// projection multiply-accumulate stage.
package q_proj_pkg;

    localparam int Q_LANES = 16;
    localparam int Q_IN_W  = 8;
    localparam int Q_ACC_W = 32;
    localparam int Q_K_MAX = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } q_acc_state_t;

    // Operands arrive sign-extended to 64 bits, so the sum is exact for any
    // accumulator width up to 62 bits; the result is clamped to acc_w bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        acc_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi  = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
        lo  = -(64'sd1 <<< (acc_w - 32'd1));
        sum = a + b;
        if (sum > hi) begin
            res = hi;
        end else if (sum < lo) begin
            res = lo;
        end else begin
            res = sum;
        end
        return res;
    endfunction

    function automatic logic sat_hit(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        acc_w
    );
        logic signed [63:0] sum;
        sum = a + b;
        return (sum > ((64'sd1 <<< (acc_w - 32'd1)) - 64'sd1)) ||
               (sum < -(64'sd1 <<< (acc_w - 32'd1)));
    endfunction

endpackage

// File: rtl/q_proj_accum_mac.sv
// One output lane: signed multiply-accumulate with clamping and a sticky
// saturation flag.
module q_sat_mac #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [IN_W-1:0]  act,
    input  logic signed [IN_W-1:0]  wgt,
    output logic signed [ACC_W-1:0] acc,
    output logic                    sat
);
    import q_proj_pkg::*;

    logic signed [2*IN_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic                      sat_q;
    logic                      sat_d;

    assign prod_s = act * wgt;

    // Next accumulator value: clear on row exit, clamp-accumulate on a beat.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
            sat_d = 1'b0;
        end else if (en) begin
            acc_d = ACC_W'(sat_add(64'(acc_q), 64'(prod_s), ACC_W));
            sat_d = sat_q | sat_hit(64'(acc_q), 64'(prod_s), ACC_W);
        end else begin
            acc_d = acc_q;
            sat_d = sat_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc = acc_q;
    assign sat = sat_q;

endmodule

// File: rtl/q_proj_accum.sv
// Q projection row accumulator: LANES saturating MACs plus the row FSM that
// emits one packed row per in_last (or per K_MAX beats) with a one-cycle strobe.
module q_proj_accum #(
    parameter int LANES = q_proj_pkg::Q_LANES,
    parameter int IN_W  = q_proj_pkg::Q_IN_W,
    parameter int ACC_W = q_proj_pkg::Q_ACC_W,
    parameter int K_MAX = q_proj_pkg::Q_K_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [IN_W-1:0]          in_act,
    input  logic [LANES*IN_W-1:0]    in_wgt,
    output logic [LANES*ACC_W-1:0]   row_data,
    output logic                     row_wen,
    output logic [LANES-1:0]         row_sat,
    output logic                     len_err
);
    import q_proj_pkg::*;

    localparam int CNT_W = $clog2(K_MAX + 1);

    q_acc_state_t     state_q;
    q_acc_state_t     state_d;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;
    logic             len_err_q;
    logic             len_err_d;
    logic             accept_s;
    logic             clr_s;

    assign accept_s = in_valid && (state_q != FLUSH);
    assign clr_s    = (state_q == FLUSH);

    // Row FSM: a beat either continues the row or closes it (last or length cap).
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (in_last) begin
                        state_d = FLUSH;
                    end else if (beat_cnt_q == CNT_W'(K_MAX - 1)) begin
                        state_d   = FLUSH;
                        len_err_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            FLUSH: begin
                state_d    = IDLE;
                beat_cnt_d = {CNT_W{1'b0}};
                len_err_d  = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = {CNT_W{1'b0}};
                len_err_d  = 1'b0;
            end
        endcase
    end

    // FSM, beat counter and length-error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= {CNT_W{1'b0}};
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            q_sat_mac #(
                .IN_W  (IN_W),
                .ACC_W (ACC_W)
            ) u_mac (
                .clk (clk),
                .rst (rst),
                .en  (accept_s),
                .clr (clr_s),
                .act (in_act),
                .wgt (in_wgt[g*IN_W +: IN_W]),
                .acc (row_data[g*ACC_W +: ACC_W]),
                .sat (row_sat[g])
            );
        end
    endgenerate

    assign in_ready = (state_q != FLUSH);
    assign row_wen  = (state_q == FLUSH);
    assign len_err  = len_err_q;

endmodule
